// File: rtl/bram_seg7_display_pkg.sv
// bram_seg7_display_pkg: shared widths, digit count and hex segment table
package bram_seg7_display_pkg;
    localparam int DIGITS = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(DIGITS);
    // Active-low {CA..CG}, entry 15 first so index n selects hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };
    function automatic logic [DIGITS-1:0] anode_mask(input logic [IDX_W-1:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction
endpackage

// File: rtl/bram_seg7_display_seg7_decoder.sv
// seg7_decoder: combinational hex nibble to active-low seven-segment pattern
module seg7_decoder
    import bram_seg7_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/bram_seg7_display.sv
// bram_seg7_display: block-RAM backed 8-digit multiplexed seven-segment scanner
// Digit n of the display shows the low nibble of memory word n.
module bram_seg7_display
    import bram_seg7_display_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int DEPTH = 1024
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d, nxt_idx;
    logic [DIGITS-1:0][3:0] buf_q, buf_d;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [3:0]             rd_nib_q;
    logic [ADDR_W-1:0]      rd_addr;
    assign tick    = cnt_q == CNT_W'(DIV - 1);
    assign nxt_idx = idx_q + 1'b1;
    // Always prefetch the digit that the next tick will load.
    assign rd_addr = ADDR_W'(nxt_idx);
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? nxt_idx : idx_q;
        buf_d = buf_q;
        if (tick) buf_d[nxt_idx] = rd_nib_q;
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end
    // Unreset array with registered read maps onto block RAM, read-before-write.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_nib_q <= mem[rd_addr][3:0];
    end
    assign an = anode_mask(idx_q);
    seg7_decoder u_dec (
        .nib_i (buf_q[idx_q]),
        .seg_o (seg)
    );
endmodule

// File: tb/tb_bram_seg7_display.sv
// tb_bram_seg7_display: directed checks of scan timing, digit loading and reset behaviour
module tb_bram_seg7_display;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] an;
    logic [6:0] seg;
    logic       tick;
    int checks = 0;
    int failures = 0;
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [7:0] init_vals [8] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78};
    int exp_dig [8] = '{1, 2, 12, 14, 5, 6, 7, 8};
    always #5 clk = ~clk;
    bram_seg7_display #(.DIV(4)) dut (
        .clk_in  (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .an      (an),
        .seg     (seg),
        .tick    (tick)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask
    task automatic wait_tick_high();
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("tick_wait", {31'b0, tick}, 1);
    endtask
    task automatic step_tick();
        wait_tick_high();
        @(posedge clk);
        @(negedge clk);
    endtask
    function automatic logic [7:0] an_of(input int d);
        logic [7:0] one = 8'h01;
        return ~(one << d);
    endfunction
    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 7'b0000001);
        check("rst_tick", tick, 0);
        for (int i = 0; i < 8; i++) wr(10'(i), init_vals[i]);
        check("rst_hold_an", an, 8'hFE);
        reset = 1'b0;
        check("tick_c1", tick, 0);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tick_e%0d", e), tick, (e % 4 == 3) ? 1 : 0);
        end
        repeat (5) step_tick();
        for (int d = 0; d < 8; d++) begin
            check($sformatf("scan_an%0d", d), an, an_of(d));
            check($sformatf("scan_seg%0d", d), seg, seg_tab[d + 1]);
            step_tick();
        end
        wr(10'd3, 8'hAF);
        repeat (3) step_tick();
        check("af_an", an, 8'hF7);
        check("af_seg", seg, 7'b0111000);
        wr(10'd3, 8'h0E);
        repeat (8) step_tick();
        check("e_seg", seg, 7'b0110000);
        repeat (6) step_tick();
        check("pre_tick_an", an, 8'hFD);
        wait_tick_high();
        wr_en = 1'b1;
        wr_addr = 10'd2;
        wr_data = 8'h0C;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("rdw_an", an, 8'hFB);
        check("rdw_old_seg", seg, seg_tab[3]);
        repeat (8) step_tick();
        check("rdw_new_seg", seg, seg_tab[12]);
        wr(10'd9, 8'h05);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("addr9_seg%0d", k), seg, seg_tab[exp_dig[(2 + k) % 8]]);
            step_tick();
        end
        repeat (3) step_tick();
        check("mid_an", an, 8'hDF);
        reset = 1'b1;
        #1;
        check("mid_rst_an", an, 8'hFE);
        check("mid_rst_seg", seg, 7'b0000001);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_tick_e%0d", e), tick, (e == 3) ? 1 : 0);
        end
        check("post_seg0", seg, seg_tab[0]);
        @(posedge clk);
        @(negedge clk);
        for (int d = 1; d < 8; d++) begin
            check($sformatf("post_an%0d", d), an, an_of(d));
            check($sformatf("post_seg%0d", d), seg, seg_tab[exp_dig[d]]);
            step_tick();
        end
        check("post_wrap_an", an, 8'hFE);
        check("post_wrap_seg", seg, seg_tab[exp_dig[0]]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_seg7_display.md
BRAM_SEG7_DISPLAY -- requirements
Module: bram_seg7_display

Interface
REQ-001 SHALL have parameter DIV, default 100000, scan-tick period in clk_in cycles (legal 2..2^20).
REQ-002 SHALL have parameter DEPTH, default 1024, memory words (address width 10).
REQ-003 SHALL have port clk_in  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe, one word per cycle when high.
REQ-006 SHALL have port wr_addr  input  10  write address.
REQ-007 SHALL have port wr_data  input  8  write data.
REQ-008 SHALL have port an  output  8  digit anodes, active-low one-hot.
REQ-009 SHALL have port seg  output  7  cathodes {CA..CG}, active-low, seg[6]=CA.
REQ-010 SHALL have port tick  output  1  one-cycle scan-tick pulse.

Function
REQ-011 Memory SHALL be DEPTH x 8, one write port, one internal read port, same clock.
REQ-012 Write SHALL occur at the clock edge where wr_en=1; wr_en=0 SHALL leave memory unchanged.
REQ-013 Read SHALL be synchronous, latency 1 cycle; read-during-write to the same address SHALL return old data.
REQ-014 Tick counter SHALL count 0..DIV-1 and wrap; tick=1 exactly in the cycle where count==DIV-1.
REQ-015 Digit index idx (0..7) SHALL advance idx+1 mod 8 on each tick; an = ~(1<<idx).
REQ-016 Read address SHALL be continuously {7'b0, (idx+1) mod 8}, so registered read data is valid before the next tick.
REQ-017 On tick, digit_buf[(idx+1) mod 8] SHALL load rd_data[3:0]; other buffer entries unchanged.
REQ-018 seg SHALL be the combinational decode of digit_buf[idx] (registered state only, no glitch path from wr_*).
REQ-019 Decode SHALL be hex, active-low: 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100,A=0001000,b=1100000,C=0110001,d=1000010,E=0110000,F=0111000.
REQ-020 Upper nibble rd_data[7:4] SHALL be ignored; addresses 8..DEPTH-1 SHALL be writable but never displayed.
REQ-021 Writes in the cycle of a tick to the address being loaded SHALL NOT affect that load (old data shown until next scan).

Reset
REQ-022 reset SHALL asynchronously set: counter=0, idx=0, an=8'b11111110, digit_buf all 0, tick=0, seg=7'b0000001.
REQ-023 Memory contents SHALL NOT be cleared by reset; power-up contents SHALL be all zero.
REQ-024 Reset asserted mid-scan SHALL restart the scan at digit 0 with a full DIV period before the first tick after release.

Structure
REQ-025 Shared package SHALL hold DIGITS=8, ADDR_W=10, DATA_W=8 and the 16-entry segment table constant.
REQ-026 One sub-module SHALL exist: seg7_decoder (4-bit nibble in, 7-bit active-low segments out, purely combinational).
REQ-027 Memory SHALL be inferred as block RAM (synchronous read, no reset on array).

Verification
REQ-028 Reset only, DIV=4 -> an=11111110, seg=0000001, tick pulses at cycles 4,8,12 after release.
REQ-029 Write addr0..7 = 0x01,0x12,0x23,0x34,0x45,0x56,0x67,0x78, DIV=4 -> after 8 ticks an cycles 11111110..01111111, seg shows 1..8 respectively on second scan.
REQ-030 Write 0xAF to addr3 -> digit 3 shows F (0111000); 0x0E -> E (0110000).
REQ-031 Write addr 2 in the exact tick cycle loading digit 2 -> old value displayed, new value after next full scan (8 ticks).
REQ-032 Write addr 9 = 0x05 -> no digit changes over 16 ticks.
REQ-033 Assert reset for 1 cycle at idx=5 -> an returns to 11111110 immediately, digit_buf zeroed, memory retained and redisplayed on next scan.
